// File: rtl/pll_lock_supervisor.sv
// Video PLL sequencer: pulses the PLL reset, waits for a stable lock, then releases the pixel domain.
// Optional LOCK_STATS_EN adds a saturating lock-loss counter output.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
`ifdef LOCK_STATS_EN
  output logic [15:0] lock_loss_cnt,
`endif
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_RESET  = 3'd0;
  localparam logic [2:0] S_WAIT   = 3'd1;
  localparam logic [2:0] S_STABLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_FAIL   = 3'd4;

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMR_MAX  = {CNT_W{1'b1}};
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRIES);

  logic             r_lock_meta, r_lock_s;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_retry;
  logic             r_pll_rst, r_vrst_n, r_ready, r_fail;

  logic [2:0]       w_nxt;
  logic [3:0]       w_retry_nxt;
  logic [3:0]       w_retry_inc;
  logic             w_tmr_clr;
  logic             w_loss;

  // pll_locked is asynchronous to refclk; only r_lock_s is used downstream
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
    end else begin
      r_lock_meta <= pll_locked;
      r_lock_s    <= r_lock_meta;
    end
  end

  assign w_retry_inc = r_retry + 4'd1;

  // restart overrides every other event evaluated in the same cycle
  always_comb begin
    w_nxt       = r_state;
    w_retry_nxt = r_retry;
    w_loss      = 1'b0;
    if (restart) begin
      w_nxt       = S_RESET;
      w_retry_nxt = 4'd0;
    end else begin
      case (r_state)
        S_RESET:  if (r_timer == RST_LAST) w_nxt = S_WAIT;
        S_WAIT: begin
          if (r_lock_s) begin
            w_nxt = S_STABLE;
          end else if (r_timer == TO_LAST) begin
            w_retry_nxt = w_retry_inc;
            w_nxt       = (w_retry_inc == RETRY_MAX) ? S_FAIL : S_RESET;
          end
        end
        S_STABLE: begin
          if (!r_lock_s) begin
            w_nxt = S_WAIT;
          end else if (r_timer == ST_LAST) begin
            w_nxt       = S_RUN;
            w_retry_nxt = 4'd0;
          end
        end
        S_RUN: begin
          if (!r_lock_s) begin
            w_nxt  = S_RESET;
            w_loss = 1'b1;
          end
        end
        S_FAIL:   w_nxt = S_FAIL;
        default:  w_nxt = S_RESET;
      endcase
    end
    w_tmr_clr = restart || (w_nxt != r_state);
  end

  // Outputs are decoded from the next state so they change on the same edge as r_state
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_timer   <= '0;
      r_retry   <= 4'd0;
      r_pll_rst <= 1'b1;
      r_vrst_n  <= 1'b0;
      r_ready   <= 1'b0;
      r_fail    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_retry   <= w_retry_nxt;
      if (w_tmr_clr)            r_timer <= '0;
      else if (r_timer != TMR_MAX) r_timer <= r_timer + 1'b1;
      r_pll_rst <= (w_nxt == S_RESET) || (w_nxt == S_FAIL);
      r_vrst_n  <= (w_nxt == S_RUN);
      r_ready   <= (w_nxt == S_RUN);
      r_fail    <= (w_nxt == S_FAIL);
    end
  end

`ifdef LOCK_STATS_EN
  logic [15:0] r_loss_cnt;

  // survives restart; only rst_n clears it
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n)                                r_loss_cnt <= 16'd0;
    else if (w_loss && r_loss_cnt != 16'hFFFF) r_loss_cnt <= r_loss_cnt + 16'd1;
  end

  assign lock_loss_cnt = r_loss_cnt;
`endif

  assign pll_rst     = r_pll_rst;
  assign video_rst_n = r_vrst_n;
  assign ready       = r_ready;
  assign fail        = r_fail;
  assign retry_cnt   = r_retry;
  assign state_dbg   = r_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (RST 4, TIMEOUT 32, STABLE 8, RETRIES 3).
// Inputs change and outputs are sampled 1 time unit after each rising refclk edge.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b1;
  logic       restart = 1'b0;
  logic       pll_locked = 1'b0;
  logic       pll_rst, video_rst_n, ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state_dbg;
`ifdef LOCK_STATS_EN
  logic [15:0] lock_loss_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(3), .CNT_W(17)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .restart(restart), .pll_locked(pll_locked),
    .pll_rst(pll_rst), .video_rst_n(video_rst_n), .ready(ready), .fail(fail),
    .retry_cnt(retry_cnt),
`ifdef LOCK_STATS_EN
    .lock_loss_cnt(lock_loss_cnt),
`endif
    .state_dbg(state_dbg)
  );

  always #5 refclk = ~refclk;

  task automatic step(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL rst_async_state: got %0d want 0", state_dbg); end
    step(3);
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
    n_cmp++; if (video_rst_n !== 1'b0) begin n_bad++; $display("FAIL rst_vrst_n: got %b want 0", video_rst_n); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", ready); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL rst_fail: got %b want 0", fail); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL rst_retry: got %0d want 0", retry_cnt); end
`ifdef LOCK_STATS_EN
    n_cmp++; if (lock_loss_cnt !== 16'd0) begin n_bad++; $display("FAIL rst_loss: got %0d want 0", lock_loss_cnt); end
`endif
    rst_n = 1'b1;
  endtask

  // Scenarios 1 and 2: reset pulse width, then lock-to-ready latency of 2+8+1
  task automatic test_lock_up();
    step(3);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL up_pll_rst_hi: got %b want 1", pll_rst); end
    step(1);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL up_pll_rst_lo: got %b want 0", pll_rst); end
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL up_wait: got %0d want 1", state_dbg); end
    step(5);
    pll_locked = 1'b1;
    step(10);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL up_ready_early: got %b want 0", ready); end
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL up_stable: got %0d want 2", state_dbg); end
    step(1);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL up_ready: got %b want 1", ready); end
    n_cmp++; if (video_rst_n !== 1'b1) begin n_bad++; $display("FAIL up_vrst_n: got %b want 1", video_rst_n); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL up_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (state_dbg !== 3'd3) begin n_bad++; $display("FAIL up_run: got %0d want 3", state_dbg); end
  endtask

  // Scenario 5: lock loss in RUN, 3-cycle response and a 4-cycle PLL reset pulse
  task automatic test_lock_loss();
    pll_locked = 1'b0;
    step(2);
    n_cmp++; if (video_rst_n !== 1'b1) begin n_bad++; $display("FAIL loss_vrst_early: got %b want 1", video_rst_n); end
    step(1);
    n_cmp++; if (video_rst_n !== 1'b0) begin n_bad++; $display("FAIL loss_vrst_n: got %b want 0", video_rst_n); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL loss_ready: got %b want 0", ready); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL loss_pll_rst: got %b want 1", pll_rst); end
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL loss_state: got %0d want 0", state_dbg); end
`ifdef LOCK_STATS_EN
    n_cmp++; if (lock_loss_cnt !== 16'd1) begin n_bad++; $display("FAIL loss_cnt: got %0d want 1", lock_loss_cnt); end
`endif
    step(3);
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL loss_pulse_hi: got %b want 1", pll_rst); end
    step(1);
    n_cmp++; if (pll_rst !== 1'b0) begin n_bad++; $display("FAIL loss_pulse_lo: got %b want 0", pll_rst); end
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL loss_wait: got %0d want 1", state_dbg); end
  endtask

  // Scenario 3: a one-cycle dropout at the end of the window forces a fresh 8-cycle window
  task automatic test_stable_glitch();
    pll_locked = 1'b1;
    step(3);
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL gl_enter: got %0d want 2", state_dbg); end
    step(5);
    pll_locked = 1'b0;
    step(1);
    pll_locked = 1'b1;
    step(1);
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL gl_still: got %0d want 2", state_dbg); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL gl_back_wait: got %0d want 1", state_dbg); end
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL gl_ready0: got %b want 0", ready); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd2) begin n_bad++; $display("FAIL gl_reenter: got %0d want 2", state_dbg); end
    step(7);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL gl_ready_early: got %b want 0", ready); end
    step(1);
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL gl_ready: got %b want 1", ready); end
  endtask

  // Scenario 4: three timed-out attempts end in FAIL, which then holds
  task automatic test_fail();
    pll_locked = 1'b0;
    step(3);
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL fl_reset: got %0d want 0", state_dbg); end
    step(4);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL fl_wait1: got %0d want 1", state_dbg); end
    step(31);
    n_cmp++; if (state_dbg !== 3'd1 || retry_cnt !== 4'd0) begin n_bad++; $display("FAIL fl_pre_to1: got st %0d rc %0d want st 1 rc 0", state_dbg, retry_cnt); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd0 || retry_cnt !== 4'd1) begin n_bad++; $display("FAIL fl_to1: got st %0d rc %0d want st 0 rc 1", state_dbg, retry_cnt); end
    step(36);
    n_cmp++; if (state_dbg !== 3'd0 || retry_cnt !== 4'd2) begin n_bad++; $display("FAIL fl_to2: got st %0d rc %0d want st 0 rc 2", state_dbg, retry_cnt); end
    step(35);
    n_cmp++; if (state_dbg !== 3'd1 || fail !== 1'b0) begin n_bad++; $display("FAIL fl_pre_to3: got st %0d fail %b want st 1 fail 0", state_dbg, fail); end
    step(1);
    n_cmp++; if (state_dbg !== 3'd4) begin n_bad++; $display("FAIL fl_state: got %0d want 4", state_dbg); end
    n_cmp++; if (fail !== 1'b1) begin n_bad++; $display("FAIL fl_fail: got %b want 1", fail); end
    n_cmp++; if (pll_rst !== 1'b1) begin n_bad++; $display("FAIL fl_pll_rst: got %b want 1", pll_rst); end
    n_cmp++; if (retry_cnt !== 4'd3) begin n_bad++; $display("FAIL fl_retry: got %0d want 3", retry_cnt); end
    step(1000);
    n_cmp++; if (state_dbg !== 3'd4 || fail !== 1'b1 || pll_rst !== 1'b1) begin n_bad++; $display("FAIL fl_hold: got st %0d fail %b prst %b want 4 1 1", state_dbg, fail, pll_rst); end
    n_cmp++; if (video_rst_n !== 1'b0 || ready !== 1'b0) begin n_bad++; $display("FAIL fl_hold_vid: got vrst %b rdy %b want 0 0", video_rst_n, ready); end
  endtask

  // Scenario 6a: restart out of FAIL; locked_s is already 1, so RUN follows 4+1+8 edges
  task automatic test_restart_fail();
    pll_locked = 1'b1;
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_cmp++; if (state_dbg !== 3'd0 || fail !== 1'b0) begin n_bad++; $display("FAIL rf_state: got st %0d fail %b want 0 0", state_dbg, fail); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL rf_retry: got %0d want 0", retry_cnt); end
    step(12);
    n_cmp++; if (ready !== 1'b0 || state_dbg !== 3'd2) begin n_bad++; $display("FAIL rf_pre_run: got rdy %b st %0d want 0 2", ready, state_dbg); end
    step(1);
    n_cmp++; if (ready !== 1'b1 || state_dbg !== 3'd3) begin n_bad++; $display("FAIL rf_run: got rdy %b st %0d want 1 3", ready, state_dbg); end
  endtask

  // Scenario 6b: restart on the edge of the third timeout wins over the FAIL transition
  task automatic test_restart_timeout();
    pll_locked = 1'b0;
    step(7);
    n_cmp++; if (state_dbg !== 3'd1) begin n_bad++; $display("FAIL rt_wait: got %0d want 1", state_dbg); end
    step(72);
    n_cmp++; if (state_dbg !== 3'd1 || retry_cnt !== 4'd2) begin n_bad++; $display("FAIL rt_wait3: got st %0d rc %0d want 1 2", state_dbg, retry_cnt); end
    step(31);
    restart = 1'b1;
    step(1);
    restart = 1'b0;
    n_cmp++; if (state_dbg !== 3'd0) begin n_bad++; $display("FAIL rt_state: got %0d want 0", state_dbg); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL rt_retry: got %0d want 0", retry_cnt); end
    n_cmp++; if (fail !== 1'b0) begin n_bad++; $display("FAIL rt_fail: got %b want 0", fail); end
`ifdef LOCK_STATS_EN
    n_cmp++; if (lock_loss_cnt !== 16'd3) begin n_bad++; $display("FAIL rt_loss_kept: got %0d want 3", lock_loss_cnt); end
`endif
  endtask

  task automatic test_async_reset();
    step(36);
    n_cmp++; if (retry_cnt !== 4'd1) begin n_bad++; $display("FAIL ar_pre_retry: got %0d want 1", retry_cnt); end
    step(4);
    n_cmp++; if (state_dbg !== 3'd1 || pll_rst !== 1'b0) begin n_bad++; $display("FAIL ar_pre_wait: got st %0d prst %b want 1 0", state_dbg, pll_rst); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (state_dbg !== 3'd0 || pll_rst !== 1'b1) begin n_bad++; $display("FAIL ar_state: got st %0d prst %b want 0 1", state_dbg, pll_rst); end
    n_cmp++; if (retry_cnt !== 4'd0) begin n_bad++; $display("FAIL ar_retry: got %0d want 0", retry_cnt); end
`ifdef LOCK_STATS_EN
    n_cmp++; if (lock_loss_cnt !== 16'd0) begin n_bad++; $display("FAIL ar_loss: got %0d want 0", lock_loss_cnt); end
`endif
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_lock_up();
    test_lock_loss();
    test_stable_glitch();
    test_fail();
    test_restart_fail();
    test_restart_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
